// File: rtl/calculator_output.sv
// Display back end for the calculator: converts a 16-bit result to BCD by
// double-dabble and scans it onto an active-low 4-digit 7-segment display.
module calculator_output #(
  parameter int SCAN_OVERFLOW = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        neg_in,
  input  logic        load,
  output logic        busy,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        led_neg
);
  localparam int SW = (SCAN_OVERFLOW > 2) ? $clog2(SCAN_OVERFLOW) : 1;

  typedef enum logic {IDLE, CONVERT} state_e;

  state_e           state_q, state_d;
  logic [15:0]      bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             negp_q, negp_d;
  logic [3:0][3:0]  dig_q, dig_d;
  logic [3:0]       mask_q, mask_d;
  logic             neg_q, neg_d;
  logic [SW-1:0]    scan_q, scan_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic [15:0]      bcd_adj;
  logic [31:0]      shifted;

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      4'hE:    seg_dec = 7'b0000110;
      default: seg_dec = 7'b1111111;
    endcase
  endfunction

  // Bit k set means digit k is a leading zero; digit 0 is never blanked.
  function automatic logic [3:0] blank_mask(input logic [15:0] d);
    logic [3:0] m;
    m[3] = (d[15:12] == 4'd0);
    m[2] = m[3] && (d[11:8] == 4'd0);
    m[1] = m[2] && (d[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    shifted = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    negp_d  = negp_q;
    dig_d   = dig_q;
    mask_d  = mask_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: if (load) begin
        if (value_in > 16'd9999) begin
          dig_d  = {4{4'hE}};
          mask_d = 4'b0000;
          neg_d  = neg_in;
        end else begin
          bin_d   = value_in;
          bcd_d   = 16'd0;
          cnt_d   = 5'd16;
          negp_d  = neg_in;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = shifted[31:16];
        bin_d = shifted[15:0];
        cnt_d = cnt_q - 5'd1;
        // Last shift: publish digits, mask and sign together.
        if (cnt_q == 5'd1) begin
          dig_d   = shifted[31:16];
          mask_d  = blank_mask(shifted[31:16]);
          neg_d   = negp_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Segment/anode registers are fed from next-state values so a new digit
  // appears on the same edge it is written.
  always_comb begin
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == SW'(SCAN_OVERFLOW - 1)) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end
    seg_d = mask_d[idx_d] ? 7'b1111111 : seg_dec(dig_d[idx_d]);
    an_d  = ~(4'b0001 << idx_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      negp_q  <= 1'b0;
      dig_q   <= '0;
      mask_q  <= 4'b1110;
      neg_q   <= 1'b0;
      scan_q  <= '0;
      idx_q   <= 2'd0;
      seg_q   <= 7'b1000000;
      an_q    <= 4'b1110;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      negp_q  <= negp_d;
      dig_q   <= dig_d;
      mask_q  <= mask_d;
      neg_q   <= neg_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign busy    = (state_q == CONVERT);
  assign seg     = seg_q;
  assign an      = an_q;
  assign dp      = 1'b1;
  assign led_neg = neg_q;
endmodule

// File: doc/calculator_output.md
# calculator_output

Display-side counterpart to the calculator's debounced input path. It accepts a binary result plus sign flag from the calculator core through a single-cycle load strobe. It converts the value to four BCD digits with an iterative shift-and-add-3 (double-dabble) engine. It then drives a multiplexed, active-low 4-digit 7-segment display with leading-zero blanking, error indication and a sign LED.

## Interface
- SCAN_OVERFLOW, default 100000: clock cycles each digit stays enabled (1 ms at 100 MHz); legal range ≥ 2.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- value_in  in  16  unsigned magnitude of result; valid when load=1.
- neg_in  in  1  result sign; valid when load=1.
- load  in  1  single-cycle strobe; captures value_in/neg_in.
- busy  out  1  conversion in progress; load ignored while high.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; constant 1 (off).
- an  out  4  digit enables, active-low one-hot; an[0] = ones digit.
- led_neg  out  1  latched sign of the displayed value.

## Operation
- FSM states: IDLE, CONVERT.
- IDLE, load=1, value_in ≤ 9999:
  - latch value_in into the shift register, clear the BCD accumulator, load the iteration counter with 16, latch neg_in.
  - go to CONVERT.
- IDLE, load=1, value_in > 9999 (error):
  - set all four digits to "E", clear the blank mask, set led_neg=neg_in.
  - stay in IDLE; busy never asserts.
- CONVERT, each cycle:
  - every BCD nibble ≥ 5 gets +3.
  - then shift {bcd[15:0], bin[15:0]} left by one.
  - decrement the counter.
  - after the 16th shift: write the four digits and the blank mask atomically, update led_neg, return to IDLE.
- Displayed digits, blank mask and led_neg hold their previous contents for the whole conversion.
- load in CONVERT is ignored; there is no queueing.
- Blank mask (leading-zero blanking):
  - digit k is blanked iff digits k..3 are all zero and k ≠ 0.
  - value 0 shows a single "0" in digit 0.
- Scan:
  - a counter runs 0..SCAN_OVERFLOW-1 continuously, independent of the FSM.
  - on wrap, the digit index advances 0→1→2→3→0.
  - an = ~(1<<index).
  - a blanked digit keeps its an low and drives seg=7'b1111111.
- Segment codes (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, E=0000110
- Reset (asserted, asynchronous):
  - state IDLE, busy=0, digits 0, mask blanks digits 3..1, led_neg=0.
  - scan counter 0, index 0 → an=4'b1110, seg=1000000, dp=1.
- Reset mid-CONVERT aborts immediately to the reset state; the partial result is discarded.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Load sampled at edge T0 (valid value): busy=1 from T0 through T16.
  - Digits, mask and led_neg update at edge T16; busy falls at the same edge.
  - seg reflects the new value from T16 onward.
- Error load at T0: digits/led_neg update at T0; seg shows "E" immediately after that edge.
- A load at the same edge busy falls (T16) is ignored. The first accepted load is at T17.
- Each index value lasts exactly SCAN_OVERFLOW cycles; a full refresh is 4·SCAN_OVERFLOW cycles.
- seg and an change on the same edge (no ghosting skew).

## Test plan
- Reset: hold reset=0 for 3 cycles, release → an=1110, seg=1000000, dp=1, busy=0, led_neg=0; with SCAN_OVERFLOW=4, an steps 1101, 1011, 0111 every 4 cycles, and digits 1–3 show seg=1111111.
- Load value_in=1234, neg_in=1:
  - busy high exactly 16 cycles; led_neg=1 after.
  - scan shows an=1110/seg=0011001, 1101/0110000, 1011/0100100, 0111/1111001.
- Load 7:
  - only digit 0 lit, showing 1111000.
  - digits 1–3 seg=1111111.
  - load 1000 → digits 0–2 show 1000000 and digit 3 shows 1111001; none blanked.
- Load 10000 and load 65535 → busy stays 0; all four digits 0000110 from the next cycle.
- Load 1234, then pulse load with 5678 at cycles 5 and 16 after the first load → both ignored; display ends on 1234. A 5678 load at cycle 17 is accepted.
- Load 9999, assert reset at cycle 8 of CONVERT → busy=0 and the display returns to the reset state; after release, load 42 → display "42" after 16 cycles, digits 2–3 blanked.
